// File: rtl/jtdd_sndcmd_if.sv
// Bus bundle between the main-CPU sound-command port and the sound CPU side.
// The master drives CPU writes and the sound-CPU acknowledge; the slave is jtdd_sndcmd.
interface jtdd_sndcmd_if;
    logic       cen;
    logic [7:0] cpu_dout;
    logic       snd_wr;
    logic       rst_req;
    logic       snd_ack;
    logic [7:0] snd_latch;
    logic       snd_irq;
    logic       snd_rstb;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output cen, cpu_dout, snd_wr, rst_req, snd_ack,
        input  snd_latch, snd_irq, snd_rstb, fifo_full, overflow
    );

    modport slave (
        input  cen, cpu_dout, snd_wr, rst_req, snd_ack,
        output snd_latch, snd_irq, snd_rstb, fifo_full, overflow
    );
endinterface

// File: rtl/jtdd_sndcmd.sv
// Sound command FIFO, latch/IRQ handshake and stretched sound-CPU reset
// for the Double Dragon sound subsystem.
module jtdd_sndcmd #(
    parameter int DEPTH  = 4,
    parameter int IRQW   = 8,
    parameter int RSTLEN = 64,
    parameter int ACKTO  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    jtdd_sndcmd_if.slave   bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int RCW = $clog2(RSTLEN + 1);
    localparam int TW  = $clog2(IRQW);
    localparam int AW  = $clog2(ACKTO + 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IRQ_HI   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_q, full_d, ovf_q, ovf_d;
    logic [7:0]      latch_q, latch_d;
    logic            irq_q, irq_d, rstb_q, rstb_d;
    logic [RCW-1:0]  rcnt_q, rcnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   ato_q, ato_d;
    logic            ack_seen_q, ack_seen_d, ack_prev_q, ack_prev_d;
    logic            rst_s, wr_s, push_s, pop_s, ack_pulse_s;

    // Next-state logic for FIFO, reset stretcher and handshake FSM
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        latch_d    = latch_q;
        irq_d      = irq_q;
        timer_d    = timer_q;
        ato_d      = ato_q;
        ack_seen_d = ack_seen_q;
        ack_prev_d = bus.snd_ack;

        rst_s       = bus.cen & bus.rst_req;
        wr_s        = bus.cen & bus.snd_wr & ~rst_s;
        ack_pulse_s = bus.snd_ack & ~ack_prev_q;
        pop_s       = (state_q == IDLE) && (cnt_q != {CW{1'b0}}) && rstb_q && !rst_s;
        // A pop in the same cycle frees the slot, so a write at full is still taken
        push_s      = wr_s && (!full_q || pop_s);

        if (rcnt_q != {RCW{1'b0}}) begin
            rcnt_d = rcnt_q - RCW'(1);
        end else begin
            rcnt_d = rcnt_q;
        end
        rstb_d = (rcnt_q <= RCW'(1));

        if (push_s) begin
            mem_d[wr_ptr_q] = bus.cpu_dout;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (wr_s && !push_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        if (rst_s) begin
            rcnt_d   = RCW'(RSTLEN);
            rstb_d   = 1'b0;
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            cnt_d    = {CW{1'b0}};
            ovf_d    = 1'b0;
            state_d  = IDLE;
            irq_d    = 1'b0;
        end else if (!rstb_q) begin
            state_d = IDLE;
            irq_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        latch_d    = mem_q[rd_ptr_q];
                        irq_d      = 1'b1;
                        timer_d    = TW'(IRQW - 1);
                        ack_seen_d = 1'b0;
                        state_d    = IRQ_HI;
                    end else begin
                        irq_d = 1'b0;
                    end
                end
                IRQ_HI: begin
                    ack_seen_d = ack_seen_q | ack_pulse_s;
                    if (timer_q == {TW{1'b0}}) begin
                        irq_d = 1'b0;
                        ato_d = AW'(ACKTO);
                        if (ack_seen_q || ack_pulse_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_ACK;
                        end
                    end else begin
                        irq_d   = 1'b1;
                        timer_d = timer_q - TW'(1);
                    end
                end
                WAIT_ACK: begin
                    irq_d = 1'b0;
                    // Timeout treats the byte as consumed so a dead sound CPU cannot stall the queue
                    if (ack_pulse_s) begin
                        state_d = IDLE;
                    end else if ((ACKTO > 32'sd0) && (ato_q == AW'(1))) begin
                        state_d = IDLE;
                    end else if (ato_q != {AW{1'b0}}) begin
                        ato_d = ato_q - AW'(1);
                    end else begin
                        ato_d = ato_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end
            endcase
        end

        full_d = (cnt_d == CW'(DEPTH));
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            latch_q    <= 8'h00;
            irq_q      <= 1'b0;
            rstb_q     <= 1'b0;
            rcnt_q     <= RCW'(RSTLEN);
            timer_q    <= {TW{1'b0}};
            ato_q      <= {AW{1'b0}};
            ack_seen_q <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            latch_q    <= latch_d;
            irq_q      <= irq_d;
            rstb_q     <= rstb_d;
            rcnt_q     <= rcnt_d;
            timer_q    <= timer_d;
            ato_q      <= ato_d;
            ack_seen_q <= ack_seen_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    assign bus.snd_latch = latch_q;
    assign bus.snd_irq   = irq_q;
    assign bus.snd_rstb  = rstb_q;
    assign bus.fifo_full = full_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_jtdd_sndcmd.sv
// Directed self-checking bench for jtdd_sndcmd (DEPTH=4, IRQW=8, RSTLEN=64, ACKTO=100).
module tb_jtdd_sndcmd;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    jtdd_sndcmd_if bus ();

    jtdd_sndcmd #(.DEPTH(4), .IRQW(8), .RSTLEN(64), .ACKTO(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait for the byte's IRQ, check latch and pulse width, then acknowledge
    task automatic expect_byte(input string tag, input logic [7:0] exp, input bit early,
                               input int min_lo, input int exp_hi);
        int lo;
        int hi;
        lo = 0;
        while (!bus.snd_irq && lo < 300) begin
            lo++;
            cycle();
        end
        check_eq({tag, " gap"}, 32'(lo >= min_lo && lo < 300), 32'd1);
        check_eq({tag, " latch"}, 32'(bus.snd_latch), 32'(exp));
        hi = 0;
        while (bus.snd_irq && hi < 50) begin
            hi++;
            bus.snd_ack = early && (hi == 3);
            cycle();
        end
        bus.snd_ack = 1'b0;
        check_eq({tag, " irq width"}, 32'(hi), 32'(exp_hi));
        if (!early) begin
            repeat (3) cycle();
            check_eq({tag, " latch hold"}, 32'(bus.snd_latch), 32'(exp));
            check_eq({tag, " irq low wait"}, 32'(bus.snd_irq), 32'd0);
            bus.snd_ack = 1'b1;
            cycle();
            bus.snd_ack = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lo;
        int         hi;
        int         k;
        bit         bad;
        logic [7:0] ovb [6];
        logic [7:0] fb  [6];
        ovb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        fb  = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.cen      = 1'b1;
        bus.cpu_dout = 8'h00;
        bus.snd_wr   = 1'b0;
        bus.rst_req  = 1'b0;
        bus.snd_ack  = 1'b0;

        // Reset state and stretch
        repeat (3) cycle();
        check_eq("rst latch", 32'(bus.snd_latch), 32'h00);
        check_eq("rst irq", 32'(bus.snd_irq), 32'd0);
        check_eq("rst rstb", 32'(bus.snd_rstb), 32'd0);
        check_eq("rst full", 32'(bus.fifo_full), 32'd0);
        check_eq("rst ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        lo  = 0;
        bad = 1'b0;
        while (!bus.snd_rstb && lo < 200) begin
            if (bus.snd_irq || bus.snd_latch != 8'h00) bad = 1'b1;
            lo++;
            cycle();
        end
        check_eq("rstb low length", 32'(lo), 32'd64);
        check_eq("irq/latch quiet in reset", 32'(bad), 32'd0);

        // cen low blocks the write
        bus.cen = 1'b0; bus.snd_wr = 1'b1; bus.cpu_dout = 8'h77;
        cycle();
        bus.cen = 1'b1; bus.snd_wr = 1'b0;
        repeat (3) cycle();
        check_eq("cen gate", 32'(bus.snd_irq), 32'd0);

        // Single command latency
        bus.snd_wr = 1'b1; bus.cpu_dout = 8'h3A;
        cycle();
        bus.snd_wr = 1'b0;
        check_eq("single irq at N", 32'(bus.snd_irq), 32'd0);
        cycle();
        check_eq("single irq at N+1", 32'(bus.snd_irq), 32'd1);
        expect_byte("single", 8'h3A, 1'b0, 0, 8);
        repeat (5) cycle();
        check_eq("single irq after ack", 32'(bus.snd_irq), 32'd0);

        // Queueing, last byte acked during the pulse
        bus.snd_wr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.cpu_dout = 8'(i);
            cycle();
        end
        bus.snd_wr = 1'b0;
        expect_byte("q1", 8'h01, 1'b0, 0, 7);
        expect_byte("q2", 8'h02, 1'b0, 1, 8);
        expect_byte("q3", 8'h03, 1'b1, 1, 8);
        repeat (3) cycle();

        // Overflow with no acks
        bus.snd_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.cpu_dout = ovb[i];
            cycle();
            if (i == 1) begin
                check_eq("ovf first load", 32'(bus.snd_latch), 32'hA1);
            end
            if (i == 4) begin
                check_eq("ovf full at 4", 32'(bus.fifo_full), 32'd1);
                check_eq("ovf clear at 4", 32'(bus.overflow), 32'd0);
            end
        end
        bus.snd_wr = 1'b0;
        check_eq("ovf full", 32'(bus.fifo_full), 32'd1);
        check_eq("ovf flag", 32'(bus.overflow), 32'd1);
        expect_byte("ovA1", 8'hA1, 1'b0, 0, 4);
        expect_byte("ovA2", 8'hA2, 1'b0, 1, 8);
        expect_byte("ovA3", 8'hA3, 1'b1, 1, 8);
        expect_byte("ovA4", 8'hA4, 1'b0, 1, 8);
        expect_byte("ovA5", 8'hA5, 1'b1, 1, 8);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.snd_irq) bad = 1'b1;
            cycle();
        end
        check_eq("ovA6 dropped", 32'(bad), 32'd0);
        check_eq("ovf sticky", 32'(bus.overflow), 32'd1);
        check_eq("ovf drained", 32'(bus.fifo_full), 32'd0);

        // rst_req mid-pulse with two queued bytes and a colliding write
        bus.snd_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cpu_dout = 8'hC1 + 8'(i);
            cycle();
        end
        bus.rst_req = 1'b1; bus.cpu_dout = 8'hC9;
        cycle();
        bus.rst_req = 1'b0; bus.snd_wr = 1'b0;
        check_eq("rreq irq", 32'(bus.snd_irq), 32'd0);
        check_eq("rreq rstb", 32'(bus.snd_rstb), 32'd0);
        check_eq("rreq latch kept", 32'(bus.snd_latch), 32'hC1);
        check_eq("rreq ovf clear", 32'(bus.overflow), 32'd0);
        check_eq("rreq full", 32'(bus.fifo_full), 32'd0);
        lo  = 0;
        bad = 1'b0;
        while (!bus.snd_rstb && lo < 200) begin
            if (bus.snd_irq) bad = 1'b1;
            lo++;
            bus.snd_wr   = (lo == 10);
            bus.cpu_dout = 8'hD1;
            cycle();
        end
        bus.snd_wr = 1'b0;
        check_eq("rreq rstb low length", 32'(lo), 32'd64);
        check_eq("rreq irq quiet", 32'(bad), 32'd0);
        cycle();
        check_eq("flush then D1 irq", 32'(bus.snd_irq), 32'd1);
        check_eq("flush then D1 latch", 32'(bus.snd_latch), 32'hD1);

        // Ack timeout: D2 queued behind an unacknowledged D1
        bus.snd_wr = 1'b1; bus.cpu_dout = 8'hD2;
        hi = 1;
        cycle();
        bus.snd_wr = 1'b0;
        while (bus.snd_irq && hi < 50) begin
            hi++;
            cycle();
        end
        check_eq("D1 irq width", 32'(hi), 32'd8);
        lo = 0;
        while (!bus.snd_irq && lo < 300) begin
            lo++;
            cycle();
        end
        check_eq("ack timeout low cycles", 32'(lo), 32'd101);
        expect_byte("toD2", 8'hD2, 1'b0, 0, 8);

        // Push and pop together while full
        bus.snd_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_dout = fb[i];
            cycle();
        end
        bus.snd_wr = 1'b0;
        check_eq("pp full before", 32'(bus.fifo_full), 32'd1);
        k = 0;
        while (bus.snd_irq && k < 50) begin
            k++;
            cycle();
        end
        repeat (2) cycle();
        bus.snd_ack = 1'b1;
        cycle();
        bus.snd_ack = 1'b0; bus.snd_wr = 1'b1; bus.cpu_dout = fb[5];
        cycle();
        bus.snd_wr = 1'b0;
        check_eq("pp full kept", 32'(bus.fifo_full), 32'd1);
        check_eq("pp no ovf", 32'(bus.overflow), 32'd0);
        check_eq("pp latch", 32'(bus.snd_latch), 32'hB1);
        expect_byte("ppB1", 8'hB1, 1'b0, 0, 8);
        expect_byte("ppB2", 8'hB2, 1'b1, 1, 8);
        expect_byte("ppB3", 8'hB3, 1'b0, 1, 8);
        expect_byte("ppB4", 8'hB4, 1'b1, 1, 8);
        expect_byte("ppB5", 8'hB5, 1'b0, 1, 8);
        check_eq("pp empty", 32'(bus.fifo_full), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
